// File: rtl/fetch_if.sv
// Fetch unit signal bundle: control handshake, instruction memory port and decoder port.
// The fetch unit connects through the master modport; its environment uses slave.
interface fetch_if;
    logic       start;
    logic       stall;
    logic [7:0] pc_inc;
    logic [7:0] pc_out;
    logic       mem_rd;
    logic       mem_ready;
    logic [7:0] instr_in;
    logic [7:0] ir_out;
    logic       ir_valid;
    logic       advance;
    logic       branch_en;
    logic [7:0] branch_target;
    logic       busy;
    logic [7:0] fetch_cnt;

    modport master (
        input  start, stall, pc_inc, mem_ready, instr_in, advance, branch_en, branch_target,
        output pc_out, mem_rd, ir_out, ir_valid, busy, fetch_cnt
    );

    modport slave (
        output start, stall, pc_inc, mem_ready, instr_in, advance, branch_en, branch_target,
        input  pc_out, mem_rd, ir_out, ir_valid, busy, fetch_cnt
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues a memory read at pc_out, latches the returned
// word into the instruction register and holds it until the decoder consumes it.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input logic    clock,
    input logic    reset,
    fetch_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    state_t     state;
    logic [7:0] pc_q;
    logic [7:0] ir_q;
    logic       ir_valid_q;
    logic       mem_rd_q;
    logic [7:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) state <= FETCH;
                end
                FETCH: begin
                    // mem_rd is registered so it is high exactly while a request is outstanding
                    if (!bus.stall) begin
                        mem_rd_q <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_ready) begin
                        ir_q       <= bus.instr_in;
                        pc_q       <= bus.pc_inc;
                        ir_valid_q <= 1'b1;
                        cnt_q      <= cnt_q + 8'd1;
                        mem_rd_q   <= 1'b0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.advance) begin
                        ir_valid_q <= 1'b0;
                        if (bus.branch_en) pc_q <= bus.branch_target;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pc_out    = pc_q;
    assign bus.ir_out    = ir_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.fetch_cnt = cnt_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [7:0] P_RESET = 8'h00;

    logic clock;
    logic reset;
    fetch_if ifc();

    fetch_unit #(.RESET_PC(P_RESET)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.master)
    );

    // external incrementer
    assign ifc.pc_inc = ifc.pc_out + 8'd1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: tracks whether the unit is active, has a request
    // outstanding, or is holding an instruction, and what it remembers.
    bit       m_active;
    bit       m_req;
    bit       m_have;
    int       m_pc;
    int       m_ir;
    int       m_cnt;

    task automatic model_reset();
        m_active = 0; m_req = 0; m_have = 0;
        m_pc = P_RESET; m_ir = 0; m_cnt = 0;
    endtask

    task automatic model_update();
        if (!m_active) begin
            if (ifc.start) m_active = 1;
        end else if (m_have) begin
            if (ifc.advance) begin
                m_have = 0;
                if (ifc.branch_en) m_pc = ifc.branch_target;
            end
        end else if (m_req) begin
            if (ifc.mem_ready) begin
                m_ir   = ifc.instr_in;
                m_pc   = (m_pc + 1) % 256;
                m_cnt  = (m_cnt + 1) % 256;
                m_have = 1;
                m_req  = 0;
            end
        end else if (!ifc.stall) begin
            m_req = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc_out"},    ifc.pc_out,            8'(m_pc));
        chk({tag, ".ir_out"},    ifc.ir_out,            8'(m_ir));
        chk({tag, ".ir_valid"},  {7'd0, ifc.ir_valid},  {7'd0, m_have});
        chk({tag, ".mem_rd"},    {7'd0, ifc.mem_rd},    {7'd0, m_req});
        chk({tag, ".busy"},      {7'd0, ifc.busy},      {7'd0, m_active});
        chk({tag, ".fetch_cnt"}, ifc.fetch_cnt,         8'(m_cnt));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        if (reset) model_update();
        #1;
        check_all(tag);
    endtask

    task automatic quiet_inputs();
        ifc.start = 0; ifc.stall = 0; ifc.mem_ready = 0; ifc.instr_in = 0;
        ifc.advance = 0; ifc.branch_en = 0; ifc.branch_target = 0;
    endtask

    // Assert reset between edges, check the asynchronous effect, release at negedge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        quiet_inputs();
        model_reset();
        #12;
        check_all("por");
        chk("por.pc_out", ifc.pc_out, P_RESET);
        @(negedge clock);
        reset = 1'b1;

        // basic fetch with minimum latency
        ifc.start = 1;
        step("s1.fetch");
        ifc.start = 0;
        step("s1.wait");
        ifc.mem_ready = 1; ifc.instr_in = 8'hA5;
        step("s1.hold");
        chk("s1.ir_valid", {7'd0, ifc.ir_valid}, 8'd1);
        chk("s1.ir_out", ifc.ir_out, 8'hA5);
        chk("s1.pc_out", ifc.pc_out, 8'h01);
        chk("s1.fetch_cnt", ifc.fetch_cnt, 8'd1);
        ifc.mem_ready = 0;
        step("s1.hold2");

        // branch out of HOLD
        ifc.advance = 1; ifc.branch_en = 1; ifc.branch_target = 8'h40;
        step("br");
        ifc.advance = 0; ifc.branch_en = 0;
        chk("br.pc_out", ifc.pc_out, 8'h40);
        chk("br.ir_valid", {7'd0, ifc.ir_valid}, 8'd0);
        chk("br.busy", {7'd0, ifc.busy}, 8'd1);

        // stall in FETCH
        ifc.stall = 1;
        repeat (3) begin
            step("stall");
            chk("stall.mem_rd", {7'd0, ifc.mem_rd}, 8'd0);
            chk("stall.busy", {7'd0, ifc.busy}, 8'd1);
        end
        ifc.stall = 0;
        step("unstall");
        chk("unstall.mem_rd", {7'd0, ifc.mem_rd}, 8'd1);
        chk("unstall.addr", ifc.pc_out, 8'h40);

        // slow memory
        repeat (4) begin
            step("slow");
            chk("slow.mem_rd", {7'd0, ifc.mem_rd}, 8'd1);
            chk("slow.pc_out", ifc.pc_out, 8'h40);
        end
        ifc.mem_ready = 1; ifc.instr_in = 8'h3C;
        chk("slow.mem_rd_last", {7'd0, ifc.mem_rd}, 8'd1);
        step("slow.done");
        ifc.mem_ready = 0;
        chk("slow.pc_out_done", ifc.pc_out, 8'h41);
        chk("slow.ir_out", ifc.ir_out, 8'h3C);

        // PC wrap after branch to FF
        ifc.advance = 1; ifc.branch_en = 1; ifc.branch_target = 8'hFF;
        step("wrap.br");
        ifc.advance = 0; ifc.branch_en = 0;
        step("wrap.wait");
        ifc.mem_ready = 1; ifc.instr_in = 8'h11;
        step("wrap.done");
        ifc.mem_ready = 0;
        chk("wrap.pc_out", ifc.pc_out, 8'h00);
        chk("wrap.fetch_cnt", ifc.fetch_cnt, 8'd3);

        // reset mid-WAIT, memory response arriving after release
        ifc.advance = 1;
        step("mr.fetch");
        ifc.advance = 0;
        step("mr.wait");
        step("mr.wait2");
        do_reset("mr.rst");
        chk("mr.busy", {7'd0, ifc.busy}, 8'd0);
        chk("mr.ir_out", ifc.ir_out, 8'h00);
        ifc.mem_ready = 1; ifc.instr_in = 8'h77;
        repeat (3) begin
            step("mr.after");
            chk("mr.after.busy", {7'd0, ifc.busy}, 8'd0);
            chk("mr.after.ir_out", ifc.ir_out, 8'h00);
            chk("mr.after.mem_rd", {7'd0, ifc.mem_rd}, 8'd0);
        end
        quiet_inputs();

        // 256 back-to-back fetches wrap fetch_cnt
        ifc.start = 1; ifc.mem_ready = 1; ifc.advance = 1; ifc.instr_in = 8'h5A;
        repeat (1 + 3 * 255 + 2) step("cnt");
        chk("cnt.wrap", ifc.fetch_cnt, 8'h00);
        chk("cnt.pc_out", ifc.pc_out, 8'h00);
        chk("cnt.ir_valid", {7'd0, ifc.ir_valid}, 8'd1);
        quiet_inputs();

        // randomized traffic
        do_reset("rnd.rst");
        for (int i = 0; i < 3000; i++) begin
            ifc.start         = ($urandom_range(0, 3) == 0);
            ifc.stall         = ($urandom_range(0, 2) == 0);
            ifc.mem_ready     = ($urandom_range(0, 2) != 0);
            ifc.instr_in      = 8'($urandom);
            ifc.advance       = ($urandom_range(0, 1) == 0);
            ifc.branch_en     = ($urandom_range(0, 3) == 0);
            ifc.branch_target = 8'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset("rnd.arst");
            else step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
